mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin arbiter that time-shares one pipelined fixed-point multiplier (`cholesky_ip_mult`, fixed latency, CE-gated) among N_REQ requesters, such as the diagonal and off-diagonal stages of the inverse/Cholesky engines. It accepts at most one operand pair per cycle and tracks each in-flight product with a requester tag. It returns every product to its originator with a one-cycle valid pulse. It also drives the multiplier clock-enable so the multiplier idles when no work is pending.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: operand/product width (Q16.16).
- `LATENCY`, 7: multiplier cycles from operands at A/B to product at P with CE high.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `hold`, in, 1: global stall; freezes arbitration and the multiplier pipeline.
- `flush`, in, 1: synchronous discard of all in-flight products.
- `req_valid`, in, N_REQ: request strobe per requester.
- `req_a`, in, N_REQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`, in, N_REQ*WIDTH: operand B, same packing as `req_a`.
- `req_ready`, out, N_REQ: combinational one-hot grant.
- `resp_valid`, out, N_REQ: one-hot product-valid pulse, registered.
- `resp_data`, out, WIDTH: product, registered.
- `mult_a`, `mult_b`, out, WIDTH: registered operands to the multiplier.
- `mult_ce`, out, 1: multiplier CE.
- `mult_p`, in, WIDTH: multiplier product.
- `in_flight`, out, $clog2(LATENCY+2): number of accepted but not-yet-returned products.

## Operation
- **Grant rule.** `req_ready` has exactly one bit set, at the first `req_valid` bit found searching upward (with wrap) from `last_grant+1`. It is all-zero when `hold`, `flush` or `!rst_n` is asserted, or when no request is present. Handshake occurs when `req_valid[i] & req_ready[i]`.
- **Round-robin pointer.** `last_grant` updates to i on each handshake. Its reset value is N_REQ-1, so requester 0 wins first.
- **On handshake:**
  - `mult_a`/`mult_b` load the granted operands.
  - Tag pipe stage 0 loads {valid=1, id=i}.
- **Without a handshake:** `mult_a`/`mult_b` hold their values and stage 0 loads valid=0.
- **Tag pipe.** Depth LATENCY+1; shifts only when `mult_ce` is 1.
- **Clock enable.** `mult_ce` is registered: `mult_ce` = !hold & (handshake this cycle | any tag valid after the shift).
- **Response.** When the last tag stage is valid with `mult_ce` high, on the next edge `resp_data` <= `mult_p` and `resp_valid` <= onehot(id). Otherwise `resp_valid` <= 0 and `resp_data` holds its value.
- **Arithmetic.** No arithmetic is performed in this block; products pass through unmodified.
- **In-flight counter.** `in_flight` increments on handshake and decrements on response issue; both in the same cycle leaves it unchanged. It never exceeds LATENCY+1.
- **Flush.** `flush` clears all tag valids, `in_flight` and the pending response. `last_grant` is kept. The multiplier data is not reset; the cleared tags mask it.
- **Async reset.** Deasserting `rst_n` mid-operation immediately clears state, and no stale response is ever emitted after reset.
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_data`=0, `mult_a`=0, `mult_b`=0, `mult_ce`=0, `in_flight`=0, all tag valids=0, `last_grant`=N_REQ-1.

## Timing
- **Latency.** A handshake in cycle 0 puts the operands on `mult_a`/`mult_b` in cycle 1 and the product on `mult_p` in cycle 1+LATENCY. `resp_valid` is high in cycle 2+LATENCY (cycle 9 for the default), for exactly one cycle.
- **Throughput.** One handshake per cycle. Responses return in acceptance order, one per cycle at most.
- **Hold.** Each cycle with `hold`=1 delays all pending responses by exactly one cycle. No response is dropped or duplicated, and no handshake occurs during hold.
- **Hold and flush together.** If `hold` and `flush` are both asserted in the same cycle, flush wins.
- **No back-pressure on responses.** Requesters must accept `resp_valid` unconditionally.

## Test plan
- **Single request.** Reset; drive `req_valid`=4'b0001 with a=0x0002_0000 (2.0) and b=0x0003_0000 (3.0) for one cycle. Expect `req_ready`=0001 in cycle 0, `resp_valid`=0001 in cycle 9 only, `resp_data`=0x0006_0000, and `in_flight` 1→0.
- **All requesters contending.** Hold `req_valid`=1111 for 8 cycles. Expect grants 0,1,2,3,0,1,2,3 on consecutive cycles, then responses in cycles 9..16 with matching one-hot ids and products.
- **Back-to-back from one requester.** Requester 2 alone for 5 cycles. Expect 5 consecutive grants, 5 consecutive responses, and `in_flight` peaking at 5.
- **Hold stall.** Accept one request in cycle 0, then `hold`=1 in cycles 3..5. Expect `mult_ce`=0 in the held cycles and `resp_valid` in cycle 12 with the correct product.
- **Flush.** Accept 3 requests, then `flush` in cycle 4. Expect no `resp_valid`, `in_flight`=0, and a following request granted to the round-robin successor.
- **Reset mid-operation.** Pulse `rst_n` low in cycle 5 with 4 requests in flight. Expect all outputs at reset values immediately, no response afterwards, and requester 0 winning the next contention.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency, CE-gated multiplier among
// N_REQ requesters. Each in-flight product carries a requester tag and returns as a one-hot pulse.
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hold,
    input  logic                         flush,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*WIDTH-1:0]       req_a,
    input  logic [N_REQ*WIDTH-1:0]       req_b,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             resp_valid,
    output logic [WIDTH-1:0]             resp_data,
    output logic [WIDTH-1:0]             mult_a,
    output logic [WIDTH-1:0]             mult_b,
    output logic                         mult_ce,
    input  logic [WIDTH-1:0]             mult_p,
    output logic [$clog2(LATENCY+2)-1:0] in_flight
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = LATENCY + 1;
    localparam int CNT_W = $clog2(LATENCY + 2);

    logic [ID_W-1:0]  last_grant;
    logic [N_REQ-1:0] grant_oh;
    logic [ID_W-1:0]  grant_id;
    logic             grant_hit;
    logic [ID_W-1:0]  scan_idx;
    logic             hs;
    logic             frozen_head;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [DEPTH-1:0] tag_vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [ID_W-1:0]  tag_id [DEPTH];
    logic             ce_nxt;
    logic             resp_issue;

    function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] r;
        r = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    // After a hold the CE register lags by one cycle; stage 0 may still hold
    // unconsumed operands then, so a new grant must wait rather than overwrite them.
    assign frozen_head = !mult_ce && tag_vld[0];

    always_comb begin
        grant_oh  = '0;
        grant_id  = '0;
        grant_hit = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!grant_hit && req_valid[scan_idx]) begin
                grant_hit          = 1'b1;
                grant_oh[scan_idx] = 1'b1;
                grant_id           = scan_idx;
            end
        end
        if (!rst_n || hold || flush || frozen_head) begin
            grant_oh  = '0;
            grant_hit = 1'b0;
        end
    end

    assign req_ready = grant_oh;
    assign hs        = grant_hit;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        vld_nxt = tag_vld;
        if (mult_ce) begin
            vld_nxt = {tag_vld[DEPTH-2:0], 1'b0};
        end
        if (hs) begin
            vld_nxt[0] = 1'b1;
        end
    end

    assign ce_nxt     = !hold && (hs || (|vld_nxt));
    assign resp_issue = mult_ce && tag_vld[DEPTH-1];

    // Control state: arbitration pointer, tag valids, CE, response strobe, counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(N_REQ - 1);
            tag_vld    <= '0;
            mult_ce    <= 1'b0;
            resp_valid <= '0;
            in_flight  <= '0;
        end else if (flush) begin
            tag_vld    <= '0;
            mult_ce    <= 1'b0;
            resp_valid <= '0;
            in_flight  <= '0;
        end else begin
            if (hs) begin
                last_grant <= grant_id;
            end
            tag_vld    <= vld_nxt;
            mult_ce    <= ce_nxt;
            resp_valid <= resp_issue ? id_onehot(tag_id[DEPTH-1]) : '0;
            case ({hs, resp_issue})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Datapath registers: operands to the multiplier and returned product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a    <= '0;
            mult_b    <= '0;
            resp_data <= '0;
        end else begin
            if (hs) begin
                mult_a <= sel_a;
                mult_b <= sel_b;
            end
            if (resp_issue && !flush) begin
                resp_data <= mult_p;
            end
        end
    end

    // Tag ids travel with the multiplier pipeline; the valids above qualify them
    always_ff @(posedge clk) begin
        if (mult_ce) begin
            for (int k = 1; k < DEPTH; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
        if (hs) begin
            tag_id[0] <= grant_id;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: table-driven grant/response vectors plus
// hand-written hold, flush and mid-operation reset sequences against a Q16.16 multiplier model.
module tb_mult_share_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 7;

    logic             clk;
    logic             rst_n;
    logic             hold;
    logic             flush;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_data;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic             mult_ce;
    logic [W-1:0]     mult_p;
    logic [$clog2(LAT+2)-1:0] in_flight;

    mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mult_a(mult_a), .mult_b(mult_b), .mult_ce(mult_ce), .mult_p(mult_p),
        .in_flight(in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CE-gated Q16.16 multiplier model with LAT register stages
    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] f;
        f = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return f[47:16];
    endfunction

    logic [31:0] mstage [LAT];
    always @(posedge clk) begin
        if (mult_ce) begin
            mstage[0] <= qmul(mult_a, mult_b);
            for (int k = 1; k < LAT; k++) mstage[k] <= mstage[k-1];
        end
    end
    assign mult_p = mstage[LAT-1];

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  ready;
        logic [3:0]  resp;
        logic [31:0] data;
        int          infl;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] prod [N];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] rv, input logic [3:0] ready, input logic [3:0] resp,
                       input logic [31:0] data, input int infl);
        vec_t v;
        v.rv = rv; v.ready = ready; v.resp = resp; v.data = data; v.infl = infl;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_table(input string tname);
        for (int c = 0; c < tbl.size(); c++) begin
            req_valid = tbl[c].rv;
            #1;
            chk($sformatf("%s c%0d ready", tname, c), 64'(req_ready), 64'(tbl[c].ready));
            chk($sformatf("%s c%0d resp_valid", tname, c), 64'(resp_valid), 64'(tbl[c].resp));
            if (tbl[c].resp != 4'b0000)
                chk($sformatf("%s c%0d resp_data", tname, c), 64'(resp_data), 64'(tbl[c].data));
            chk($sformatf("%s c%0d in_flight", tname, c), 64'(in_flight), 64'(tbl[c].infl));
            step();
        end
        req_valid = '0;
        tbl.delete();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        // r0: 2.0*3.0, r1: 2.0*-1.5, r2: 0.25*4.0, r3: 1.5*2.5
        req_a = {32'h0001_8000, 32'h0000_4000, 32'h0002_0000, 32'h0002_0000};
        req_b = {32'h0002_8000, 32'h0004_0000, 32'hFFFE_8000, 32'h0003_0000};
        prod[0] = 32'h0006_0000; prod[1] = 32'hFFFD_0000;
        prod[2] = 32'h0001_0000; prod[3] = 32'h0003_C000;
        hold = 1'b0; flush = 1'b0;

        rst_n = 1'b0; req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'h0);
        chk("reset resp_valid", 64'(resp_valid), 64'h0);
        chk("reset resp_data", 64'(resp_data), 64'h0);
        chk("reset mult_a", 64'(mult_a), 64'h0);
        chk("reset mult_b", 64'(mult_b), 64'h0);
        chk("reset mult_ce", 64'(mult_ce), 64'h0);
        chk("reset in_flight", 64'(in_flight), 64'h0);

        // Single request from requester 0
        do_reset();
        add(4'b0001, 4'b0001, 4'b0000, 32'h0, 0);
        for (int c = 1; c <= 8; c++) add(4'b0000, 4'b0000, 4'b0000, 32'h0, 1);
        add(4'b0000, 4'b0000, 4'b0001, prod[0], 0);
        add(4'b0000, 4'b0000, 4'b0000, 32'h0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 32'h0, 0);
        run_table("single");

        // All four contending for 8 cycles
        do_reset();
        for (int c = 0; c < 18; c++) begin
            logic [3:0] rdy, rsp;
            logic [31:0] d;
            int infl;
            rdy  = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            rsp  = (c >= 9 && c <= 16) ? 4'(1 << ((c - 9) % 4)) : 4'b0000;
            d    = (c >= 9 && c <= 16) ? prod[(c - 9) % 4] : 32'h0;
            infl = (c <= 8) ? c : ((c <= 16) ? 16 - c : 0);
            add((c < 8) ? 4'b1111 : 4'b0000, rdy, rsp, d, infl);
        end
        run_table("contend");

        // Requester 2 back-to-back for 5 cycles
        do_reset();
        for (int c = 0; c < 15; c++) begin
            int infl;
            infl = (c <= 5) ? c : ((c <= 8) ? 5 : ((c <= 13) ? 13 - c : 0));
            add((c < 5) ? 4'b0100 : 4'b0000, (c < 5) ? 4'b0100 : 4'b0000,
                (c >= 9 && c <= 13) ? 4'b0100 : 4'b0000,
                (c >= 9 && c <= 13) ? prod[2] : 32'h0, infl);
        end
        run_table("b2b");

        // Hold in cycles 3..5 delays the response from cycle 9 to 12
        do_reset();
        for (int c = 0; c < 14; c++) begin
            req_valid = (c == 0) ? 4'b0001 : ((c >= 3 && c <= 5) ? 4'b0010 : 4'b0000);
            hold = (c >= 3 && c <= 5);
            #1;
            if (c == 0) chk("hold grant", 64'(req_ready), 64'h1);
            if (c >= 3 && c <= 5) chk($sformatf("hold c%0d ready", c), 64'(req_ready), 64'h0);
            if (c == 2) chk("hold c2 mult_ce", 64'(mult_ce), 64'h1);
            if (c == 4 || c == 5) chk($sformatf("hold c%0d mult_ce", c), 64'(mult_ce), 64'h0);
            if (c == 11) chk("hold c11 in_flight", 64'(in_flight), 64'h1);
            chk($sformatf("hold c%0d resp_valid", c), 64'(resp_valid), (c == 12) ? 64'h1 : 64'h0);
            if (c == 12) begin
                chk("hold resp_data", 64'(resp_data), 64'(prod[0]));
                chk("hold c12 in_flight", 64'(in_flight), 64'h0);
            end
            step();
        end
        hold = 1'b0;
        req_valid = '0;

        // Flush after three accepts; next grant goes to the round-robin successor
        do_reset();
        for (int c = 0; c < 16; c++) begin
            req_valid = (c <= 2) ? 4'b0111 : ((c == 4 || c == 5) ? 4'b1111 : 4'b0000);
            flush = (c == 4);
            #1;
            if (c <= 2) chk($sformatf("flush c%0d ready", c), 64'(req_ready), 64'(1 << c));
            if (c == 4) begin
                chk("flush c4 ready", 64'(req_ready), 64'h0);
                chk("flush c4 in_flight", 64'(in_flight), 64'h3);
            end
            if (c == 5) begin
                chk("flush c5 ready", 64'(req_ready), 64'h8);
                chk("flush c5 in_flight", 64'(in_flight), 64'h0);
            end
            chk($sformatf("flush c%0d resp_valid", c), 64'(resp_valid), (c == 14) ? 64'h8 : 64'h0);
            if (c == 14) chk("flush resp_data", 64'(resp_data), 64'(prod[3]));
            step();
        end
        flush = 1'b0;
        req_valid = '0;

        // Asynchronous reset in cycle 5 with four products in flight
        do_reset();
        for (int c = 0; c < 17; c++) begin
            req_valid = (c <= 3 || c == 5 || c == 6) ? 4'b1111 : 4'b0000;
            if (c == 5) rst_n = 1'b0;
            if (c == 6) rst_n = 1'b1;
            #1;
            if (c == 4) chk("rst c4 in_flight", 64'(in_flight), 64'h4);
            if (c == 5) begin
                chk("rst ready", 64'(req_ready), 64'h0);
                chk("rst resp_valid", 64'(resp_valid), 64'h0);
                chk("rst mult_a", 64'(mult_a), 64'h0);
                chk("rst mult_b", 64'(mult_b), 64'h0);
                chk("rst mult_ce", 64'(mult_ce), 64'h0);
                chk("rst in_flight", 64'(in_flight), 64'h0);
            end
            if (c == 6) chk("rst next grant", 64'(req_ready), 64'h1);
            if (c >= 6) chk($sformatf("rst c%0d resp_valid", c), 64'(resp_valid),
                            (c == 15) ? 64'h1 : 64'h0);
            if (c == 15) chk("rst resp_data", 64'(resp_data), 64'(prod[0]));
            step();
        end
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
